// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA engine and its PPU neighbours.
package oam_dma_pkg;

   localparam int OAM_SIZE = 160;

   typedef enum logic [1:0] {
      DMA_IDLE,
      DMA_DELAY,
      DMA_COPY,
      DMA_DRAIN
   } dma_state_t;

   // Low byte of the I/O register addresses in the 0xFFxx page.
   typedef enum logic [7:0] {
      PPU_LCDC = 8'h40,
      PPU_SCY  = 8'h42,
      PPU_SCX  = 8'h43,
      PPU_DMA  = 8'h46
   } ppu_reg_t;

   // Echo RAM at E0..FF mirrors work RAM at C0..DF.
   function automatic logic [7:0] echoMap(input logic [7:0] hi);
      return (hi >= 8'hE0) ? (hi & 8'hDF) : hi;
   endfunction

endpackage

// File: rtl/oam_dma_if.sv
// Register, source-bus and OAM-write signals of the OAM DMA engine.
interface oam_dma_if;
   import oam_dma_pkg::*;

   logic        reg_write;
   logic [7:0]  reg_d_wr;
   logic [7:0]  reg_d_rd;
   logic [15:0] bus_addr;
   logic        bus_rd;
   logic [7:0]  bus_d_rd;
   logic [7:0]  oam_addr;
   logic        oam_write;
   logic [7:0]  oam_d_wr;
   logic        active;

   modport master (
      input  reg_write, reg_d_wr, bus_d_rd,
      output reg_d_rd, bus_addr, bus_rd, oam_addr, oam_write, oam_d_wr, active
   );

   modport slave (
      output reg_write, reg_d_wr, bus_d_rd,
      input  reg_d_rd, bus_addr, bus_rd, oam_addr, oam_write, oam_d_wr, active
   );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LEN bytes from page {src_hi, 00} into OAM.
// Optional macro OAM_DMA_ECHO_EN remaps echo-RAM source pages E0..FF to C0..DF.
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int LEN         = OAM_SIZE,
   parameter int START_DELAY = 1
) (
   input  logic      clk,
   input  logic      reset,
   oam_dma_if.master dmaIf
);

   if (LEN > 256 || LEN < 1) begin : g_badLen
      $error("oam_dma: LEN must be in 1..256");
   end
   if (START_DELAY > 7 || START_DELAY < 0) begin : g_badDelay
      $error("oam_dma: START_DELAY must be in 0..7");
   end

   localparam logic [7:0] LAST_IDX    = 8'(LEN - 1);
   localparam logic [2:0] DELAY_LAST  = 3'((START_DELAY > 0) ? START_DELAY - 1 : 0);
   localparam dma_state_t START_STATE = (START_DELAY == 0) ? DMA_COPY : DMA_DELAY;

   dma_state_t r_state;
   dma_state_t w_nextState;
   logic [7:0] r_srcHi;
   logic [7:0] r_regDRd;
   logic [7:0] r_count;
   logic [2:0] r_delay;
   logic [7:0] r_oamAddr;
   logic       r_oamWrite;
   logic [7:0] w_srcHiEff;

`ifdef OAM_DMA_ECHO_EN
   assign w_srcHiEff = echoMap(r_srcHi);
`else
   assign w_srcHiEff = r_srcHi;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= DMA_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A register write in any state (re)starts the transfer.
   always_comb begin
      w_nextState    = r_state;
      dmaIf.bus_rd   = 1'b0;
      dmaIf.bus_addr = '0;
      dmaIf.active   = 1'b0;
      case (r_state)
         DMA_IDLE: begin
         end
         DMA_DELAY: begin
            dmaIf.active = 1'b1;
            if (r_delay == DELAY_LAST) w_nextState = DMA_COPY;
         end
         DMA_COPY: begin
            dmaIf.active   = 1'b1;
            dmaIf.bus_rd   = 1'b1;
            dmaIf.bus_addr = {w_srcHiEff, r_count};
            if (r_count == LAST_IDX) w_nextState = DMA_DRAIN;
         end
         DMA_DRAIN: begin
            dmaIf.active = 1'b1;
            w_nextState  = DMA_IDLE;
         end
         default: w_nextState = DMA_IDLE;
      endcase
      if (dmaIf.reg_write) w_nextState = START_STATE;
   end

   // The OAM write trails its source read by one cycle; a restart squashes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_srcHi    <= '0;
         r_regDRd   <= '0;
         r_count    <= '0;
         r_delay    <= '0;
         r_oamAddr  <= '0;
         r_oamWrite <= 1'b0;
      end else begin
         r_oamWrite <= (r_state == DMA_COPY) && !dmaIf.reg_write;
         if (r_state == DMA_COPY) r_oamAddr <= r_count;
         if (dmaIf.reg_write) begin
            r_srcHi  <= dmaIf.reg_d_wr;
            r_regDRd <= dmaIf.reg_d_wr;
            r_count  <= '0;
            r_delay  <= '0;
         end else if (r_state == DMA_COPY) begin
            r_count <= r_count + 8'd1;
         end else if (r_state == DMA_DELAY) begin
            r_delay <= r_delay + 3'd1;
         end
      end
   end

   assign dmaIf.reg_d_rd  = r_regDRd;
   assign dmaIf.oam_addr  = r_oamAddr;
   assign dmaIf.oam_write = r_oamWrite;
   assign dmaIf.oam_d_wr  = r_oamWrite ? dmaIf.bus_d_rd : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma: one DUT with START_DELAY=1, one with 0.
module tb_oam_dma;
   import oam_dma_pkg::*;

   localparam int LEN = OAM_SIZE;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   oam_dma_if busIf();
   oam_dma_if fastIf();

   oam_dma #(.LEN(LEN), .START_DELAY(1)) dut (
      .clk   (clk),
      .reset (reset),
      .dmaIf (busIf.master)
   );

   oam_dma #(.LEN(LEN), .START_DELAY(0)) dutFast (
      .clk   (clk),
      .reset (reset),
      .dmaIf (fastIf.master)
   );

   logic [7:0] mem [65536];
   logic [7:0] oam [256];
   logic [7:0] oamFast [256];

   int checks = 0;
   int errors = 0;
   int cyc, act, firstRd, nWr, rdIdx, badAddr;
   int actFast, nWrFast;
   logic [7:0] expHi;
   logic [7:0] lastWr;

   // Source memory with one-cycle read latency.
   always @(posedge clk) begin
      busIf.bus_d_rd  <= mem[busIf.bus_addr];
      fastIf.bus_d_rd <= mem[fastIf.bus_addr];
   end

   function automatic logic [7:0] memVal(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [7:0] d);
      busIf.reg_write = we;
      busIf.reg_d_wr  = d;
   endtask

   task automatic clearObs();
      cyc = 0; act = 0; firstRd = -1; nWr = 0; rdIdx = 0; badAddr = 0; lastWr = 8'h00;
      actFast = 0; nWrFast = 0;
   endtask

   task automatic fillOam(input logic [7:0] v);
      for (int i = 0; i < 256; i++) oam[i] = v;
   endtask

   // Records the cycle that has just begun for both DUTs.
   task automatic observe();
      cyc++;
      if (busIf.active === 1'b1) act++;
      if ((busIf.bus_rd === 1'b1 || busIf.oam_write === 1'b1) && busIf.active !== 1'b1) badAddr++;
      if (busIf.bus_rd === 1'b1) begin
         if (firstRd < 0) firstRd = cyc;
         if (busIf.bus_addr !== {expHi, rdIdx[7:0]}) badAddr++;
         rdIdx++;
      end
      if (busIf.oam_write === 1'b1) begin
         if (busIf.oam_addr >= LEN) badAddr++;
         oam[busIf.oam_addr] = busIf.oam_d_wr;
         lastWr = busIf.oam_addr;
         nWr++;
      end
      if (fastIf.active === 1'b1) actFast++;
      if (fastIf.oam_write === 1'b1) begin
         oamFast[fastIf.oam_addr] = fastIf.oam_d_wr;
         nWrFast++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      observe();
   endtask

   task automatic runToIdle(input string tag, input bit fast);
      int g;
      g = 0;
      while (((fast ? fastIf.active : busIf.active) === 1'b1) && g < 400) begin
         step();
         g++;
      end
      checkOutput(tag, 32'(g >= 400), 32'd0);
   endtask

   task automatic runUntilReads(input string tag, input int n);
      int g;
      g = 0;
      while (rdIdx < n && g < 400) begin
         step();
         g++;
      end
      checkOutput(tag, 32'(g >= 400), 32'd0);
   endtask

   function automatic int oamBad(input logic [7:0] hi);
      int bad;
      bad = 0;
      for (int i = 0; i < LEN; i++) if (oam[i] !== memVal({hi, 8'(i)})) bad++;
      return bad;
   endfunction

   function automatic int oamFastBad(input logic [7:0] hi);
      int bad;
      bad = 0;
      for (int i = 0; i < LEN; i++) if (oamFast[i] !== memVal({hi, 8'(i)})) bad++;
      return bad;
   endfunction

   initial begin
      int untouched;
      int wrBefore;

      applyStimulus(1'b0, 8'h00);
      fastIf.reg_write = 1'b0;
      fastIf.reg_d_wr  = 8'h00;
      for (int a = 0; a < 65536; a++) mem[a] = memVal(16'(a));
      expHi = 8'h00;
      clearObs();

      // Reset state
      reset = 1'b1;
      repeat (3) step();
      checkOutput("rst_active", 32'(busIf.active), 32'd0);
      checkOutput("rst_bus_rd", 32'(busIf.bus_rd), 32'd0);
      checkOutput("rst_oam_write", 32'(busIf.oam_write), 32'd0);
      checkOutput("rst_bus_addr", 32'(busIf.bus_addr), 32'd0);
      checkOutput("rst_oam_addr", 32'(busIf.oam_addr), 32'd0);
      checkOutput("rst_oam_d_wr", 32'(busIf.oam_d_wr), 32'd0);
      checkOutput("rst_reg_d_rd", 32'(busIf.reg_d_rd), 32'd0);

      // Reset beats a simultaneous register write
      applyStimulus(1'b1, 8'hC0);
      step();
      applyStimulus(1'b0, 8'h00);
      reset = 1'b0;
      step();
      checkOutput("rstprio_active", 32'(busIf.active), 32'd0);
      checkOutput("rstprio_reg_d_rd", 32'(busIf.reg_d_rd), 32'd0);

      // Plain transfer from page C0
      fillOam(8'hEE);
      expHi = 8'hC0;
      applyStimulus(1'b1, 8'hC0);
      clearObs();
      step();
      applyStimulus(1'b0, 8'h00);
      runToIdle("basic_timeout", 1'b0);
      checkOutput("basic_first_rd", 32'(firstRd), 32'd2);
      checkOutput("basic_active_len", 32'(act), 32'd162);
      checkOutput("basic_writes", 32'(nWr), 32'd160);
      checkOutput("basic_last_addr", 32'(lastWr), 32'h9F);
      checkOutput("basic_reads", 32'(rdIdx), 32'd160);
      checkOutput("basic_bad_addr", 32'(badAddr), 32'd0);
      checkOutput("basic_oam_bad", 32'(oamBad(8'hC0)), 32'd0);
      checkOutput("basic_reg_d_rd", 32'(busIf.reg_d_rd), 32'hC0);

      // Restart with page D0 during the 50th copy cycle
      fillOam(8'hEE);
      expHi = 8'hC0;
      applyStimulus(1'b1, 8'hC0);
      clearObs();
      step();
      applyStimulus(1'b0, 8'h00);
      runUntilReads("restart_reach", 50);
      applyStimulus(1'b1, 8'hD0);
      expHi = 8'hD0;
      rdIdx = 0;
      step();
      applyStimulus(1'b0, 8'h00);
      checkOutput("restart_squash", 32'(busIf.oam_write), 32'd0);
      checkOutput("restart_bus_rd", 32'(busIf.bus_rd), 32'd0);
      checkOutput("restart_active", 32'(busIf.active), 32'd1);
      checkOutput("restart_reg_d_rd", 32'(busIf.reg_d_rd), 32'hD0);
      step();
      checkOutput("restart_first_addr", 32'(busIf.bus_addr), 32'hD000);
      runToIdle("restart_timeout", 1'b0);
      checkOutput("restart_reads", 32'(rdIdx), 32'd160);
      checkOutput("restart_bad_addr", 32'(badAddr), 32'd0);
      checkOutput("restart_oam_bad", 32'(oamBad(8'hD0)), 32'd0);

      // Reset during the 80th copy cycle
      fillOam(8'h33);
      expHi = 8'hC0;
      applyStimulus(1'b1, 8'hC0);
      clearObs();
      step();
      applyStimulus(1'b0, 8'h00);
      runUntilReads("abort_reach", 80);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("abort_active", 32'(busIf.active), 32'd0);
      checkOutput("abort_bus_rd", 32'(busIf.bus_rd), 32'd0);
      checkOutput("abort_oam_write", 32'(busIf.oam_write), 32'd0);
      wrBefore = nWr;
      repeat (5) step();
      checkOutput("abort_no_writes", 32'(nWr), 32'(wrBefore));
      untouched = 0;
      for (int i = 79; i < LEN; i++) if (oam[i] !== 8'h33) untouched++;
      checkOutput("abort_oam_tail", 32'(untouched), 32'd0);
      checkOutput("abort_oam_78", 32'(oam[78]), 32'(memVal(16'hC04E)));

      // Echo-page source address
`ifdef OAM_DMA_ECHO_EN
      expHi = 8'hDE;
`else
      expHi = 8'hFE;
`endif
      fillOam(8'hEE);
      applyStimulus(1'b1, 8'hFE);
      clearObs();
      step();
      applyStimulus(1'b0, 8'h00);
      runToIdle("echo_timeout", 1'b0);
      checkOutput("echo_reg_d_rd", 32'(busIf.reg_d_rd), 32'hFE);
      checkOutput("echo_reads", 32'(rdIdx), 32'd160);
      checkOutput("echo_bad_addr", 32'(badAddr), 32'd0);
      checkOutput("echo_oam_bad", 32'(oamBad(expHi)), 32'd0);

      // Zero start delay on the second instance
      for (int i = 0; i < 256; i++) oamFast[i] = 8'hEE;
      fastIf.reg_write = 1'b1;
      fastIf.reg_d_wr  = 8'h80;
      clearObs();
      step();
      fastIf.reg_write = 1'b0;
      fastIf.reg_d_wr  = 8'h00;
      checkOutput("fast_first_rd", 32'(fastIf.bus_rd), 32'd1);
      checkOutput("fast_first_addr", 32'(fastIf.bus_addr), 32'h8000);
      runToIdle("fast_timeout", 1'b1);
      checkOutput("fast_active_len", 32'(actFast), 32'd161);
      checkOutput("fast_writes", 32'(nWrFast), 32'd160);
      checkOutput("fast_oam_bad", 32'(oamFastBad(8'h80)), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
